tqvp_hx2003_pulse_receiver: RTL and testbench

TinyQV peripheral that captures a pulse train on one `ui_in` pin and decodes it into 2-bit symbols: a level bit plus a short/long bit. Symbols are packed 16 per 32-bit word, in the same format the pulse transmitter consumes, so a capture can be replayed unchanged. It sits beside the transmitter on the TinyQV peripheral bus and uses the standard peripheral port set.

---
 rtl/pulse_receiver_pkg.sv | 45 ++++
 rtl/pulse_receiver_glitch_filter.sv | 43 ++++
 rtl/tqvp_hx2003_pulse_receiver.sv | 230 +++++++++++++++++++++++
 tb/tb_tqvp_hx2003_pulse_receiver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_receiver_pkg.sv
// Shared constants for the pulse receiver: register map, status bits, FSM states
// and the 2-bit symbol format also consumed by the pulse transmitter.
package pulse_receiver_pkg;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_CFG      = 6'h04;
    localparam logic [5:0] ADDR_CFG2     = 6'h08;
    localparam int         ADDR_MEM_BIT  = 5;

    localparam int ST_SYMBOL  = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_FULL    = 3;
    localparam int ST_IDX64   = 4;

    localparam int CTRL_IEN_LSB  = 8;
    localparam int CTRL_IDLE_BIT = 12;
    localparam int CTRL_INV_BIT  = 13;
    localparam int CTRL_TMO_LSB  = 16;

    localparam int CFG_THR_LO_LSB = 0;
    localparam int CFG_THR_HI_LSB = 8;
    localparam int CFG_PRESC_LSB  = 16;
    localparam int CFG_GLITCH_LSB = 20;
    localparam int CFG_SEL_LSB    = 24;

    localparam int SYM_W          = 2;
    localparam int SYMS_PER_WORD  = 16;

    localparam logic [1:0] WR_8    = 2'b00;
    localparam logic [1:0] WR_16   = 2'b01;
    localparam logic [1:0] WR_32   = 2'b10;
    localparam logic [1:0] WR_NONE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic level;
        logic long_pulse;
    } symbol_t;

endpackage

// File: rtl/pulse_receiver_glitch_filter.sv
// Debounces the selected input: the output level follows raw only after raw has
// disagreed with it for g+1 consecutive clocks; level_edge pulses on each change.
module pulse_receiver_glitch_filter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    input  logic [3:0] g,
    input  logic       load,
    input  logic       load_level,
    output logic       level,
    output logic       level_edge
);

    logic [3:0] run_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= 1'b0;
            level_edge <= 1'b0;
            run_cnt    <= '0;
        end else begin
            level_edge <= 1'b0;
            if (load) begin
                level   <= load_level;
                run_cnt <= '0;
            end else if (raw != level) begin
                // >= keeps the filter from stalling if g is lowered mid-count
                if (run_cnt >= g) begin
                    level      <= raw;
                    level_edge <= 1'b1;
                    run_cnt    <= '0;
                end else begin
                    run_cnt <= run_cnt + 4'd1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// TinyQV peripheral that measures pulses on one ui_in pin and stores them as
// 2-bit {level, long} symbols, 16 per word, in transmitter-compatible format.
module tqvp_hx2003_pulse_receiver
    import pulse_receiver_pkg::*;
#(
    parameter int NUM_DATA_REG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int         CAPACITY = NUM_DATA_REG * SYMS_PER_WORD;
    localparam int         WORD_W   = (NUM_DATA_REG > 1) ? $clog2(NUM_DATA_REG) : 1;
    localparam logic [6:0] IDX_MASK = 7'(CAPACITY - 1);

    // Control / configuration registers
    logic        run;
    logic [4:1]  status;
    logic [4:1]  ien;
    logic        idle_level;
    logic        invert;
    logic [15:0] timeout;
    logic [31:0] cfg;
    logic [6:0]  end_index;

    // Capture datapath
    rx_state_e   state, state_next;
    logic [6:0]  index;
    logic [15:0] count;
    logic [15:0] prescaler;
    logic [15:0] last_duration;
    logic [31:0] mem [NUM_DATA_REG];

    // Filter and decode signals
    logic        raw;
    logic        level;
    logic        level_edge;
    logic [15:0] presc_max;
    logic        tick;
    logic [15:0] count_inc;
    logic [6:0]  idx_inc;
    logic [7:0]  thr;
    symbol_t     sym;
    logic        sym_we;
    logic        hw_end;
    logic [4:1]  set_bits;

    // Bus decode
    logic        wr_any, wr_32, wr_16up;
    logic        ctrl_wr, cfg_wr, cfg2_wr, mem_wr;
    logic        cpu_start, cpu_abort;
    logic        next_idle_level;
    logic        unused_ok;

    assign wr_any  = (data_write_n != WR_NONE);
    assign wr_32   = (data_write_n == WR_32);
    assign wr_16up = wr_32 || (data_write_n == WR_16);
    assign ctrl_wr = wr_any && (address == ADDR_CTRL);
    assign cfg_wr  = wr_32 && (address == ADDR_CFG);
    assign cfg2_wr = wr_32 && (address == ADDR_CFG2);
    assign mem_wr  = wr_32 && address[ADDR_MEM_BIT];

    // A hardware end in the same cycle as a run=1 write counts as a restart
    assign cpu_start = ctrl_wr && data_in[0] && (!run || hw_end);
    assign cpu_abort = ctrl_wr && !data_in[0];

    assign next_idle_level = (ctrl_wr && wr_16up) ? data_in[CTRL_IDLE_BIT] : idle_level;
    assign raw = ui_in[cfg[CFG_SEL_LSB +: 3]] ^ invert;

    pulse_receiver_glitch_filter u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (raw),
        .g          (cfg[CFG_GLITCH_LSB +: 4]),
        .load       (cpu_start),
        .load_level (next_idle_level),
        .level      (level),
        .level_edge (level_edge)
    );

    assign presc_max = (16'd1 << cfg[CFG_PRESC_LSB +: 4]) - 16'd1;
    assign idx_inc   = (index + 7'd1) & IDX_MASK;
    // level is the new level, so the pulse that just ended had the opposite one
    assign thr       = level ? cfg[CFG_THR_LO_LSB +: 8] : cfg[CFG_THR_HI_LSB +: 8];

    always_comb begin
        state_next = state;
        tick       = 1'b0;
        count_inc  = count;
        sym        = '0;
        sym_we     = 1'b0;
        hw_end     = 1'b0;
        set_bits   = '0;
        unique case (state)
            S_IDLE: ;
            S_ARM: begin
                if (level != idle_level) state_next = S_MEASURE;
            end
            S_MEASURE: begin
                tick = (prescaler == presc_max);
                if (tick && count != 16'hFFFF) count_inc = count + 16'd1;
                if (level_edge) begin
                    sym.level            = ~level;
                    sym.long_pulse       = count_inc > {8'd0, thr};
                    sym_we               = 1'b1;
                    set_bits[ST_SYMBOL]  = 1'b1;
                    if (index == end_index) begin
                        set_bits[ST_FULL] = 1'b1;
                        hw_end            = 1'b1;
                        state_next        = S_IDLE;
                    end else if (idx_inc == 7'd64) begin
                        set_bits[ST_IDX64] = 1'b1;
                    end
                end else if (timeout != 16'd0 && count_inc == timeout) begin
                    set_bits[ST_TIMEOUT] = 1'b1;
                    hw_end               = 1'b1;
                    state_next           = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (cpu_abort) begin
            state_next = S_IDLE;
            sym_we     = 1'b0;
            hw_end     = 1'b0;
            set_bits   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= cpu_start ? S_ARM : state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            status     <= '0;
            ien        <= '0;
            idle_level <= 1'b0;
            invert     <= 1'b0;
            timeout    <= '0;
            cfg        <= '0;
            end_index  <= '0;
        end else begin
            if (cpu_start)      run <= 1'b1;
            else if (cpu_abort) run <= 1'b0;
            else if (hw_end)    run <= 1'b0;

            // Hardware set wins over a same-cycle write-1-to-clear
            status <= (status & ~(ctrl_wr ? data_in[4:1] : 4'b0)) | (set_bits & ien);

            if (ctrl_wr && wr_16up) begin
                ien        <= data_in[CTRL_IEN_LSB +: 4];
                idle_level <= data_in[CTRL_IDLE_BIT];
                invert     <= data_in[CTRL_INV_BIT];
            end
            if (ctrl_wr && wr_32) timeout <= data_in[CTRL_TMO_LSB +: 16];
            if (cfg_wr)  cfg       <= data_in;
            if (cfg2_wr) end_index <= data_in[6:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index         <= '0;
            count         <= '0;
            prescaler     <= '0;
            last_duration <= '0;
        end else begin
            if (sym_we) last_duration <= count_inc;
            if (cpu_start) begin
                index     <= '0;
                count     <= '0;
                prescaler <= '0;
            end else if (state == S_ARM && state_next == S_MEASURE) begin
                count <= '0;
            end else if (state == S_MEASURE && !cpu_abort) begin
                prescaler <= tick ? 16'd0 : prescaler + 16'd1;
                count     <= count_inc;
                if (sym_we) begin
                    count     <= '0;
                    prescaler <= '0;
                    if (!hw_end) index <= idx_inc;
                end
            end
        end
    end

    // NOTE: the symbol memory has no reset so captured or CPU-written words
    // survive a reset for readback; software clears it with word writes.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[address[2 +: WORD_W]] <= data_in;
        // Later assignment wins, so the 2-bit hardware update lands on top of
        // a same-cycle CPU word write
        if (sym_we) mem[index[4 +: WORD_W]][{index[3:0], 1'b0} +: SYM_W] <= sym;
    end

    always_comb begin
        data_out = '0;
        if (address[ADDR_MEM_BIT]) begin
            data_out = mem[address[2 +: WORD_W]];
        end else begin
            unique case (address)
                ADDR_CTRL: data_out = {count, 1'b0, index, 3'b0, status, run};
                ADDR_CFG:  data_out = cfg;
                ADDR_CFG2: data_out = {last_duration, 9'b0, end_index};
                default:   data_out = '0;
            endcase
        end
    end

    assign uo_out         = {4'b0, (state == S_MEASURE), level, 2'b0};
    assign data_ready     = 1'b1;
    assign user_interrupt = |status;
    assign unused_ok      = &{1'b0, data_read_n};

endmodule

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// Directed bench for the pulse receiver: decode, timeout, glitch filter, abort,
// restart, W1C/set collision, interrupt mask, async reset and index-64 status.
module tb_tqvp_hx2003_pulse_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tqvp_hx2003_pulse_receiver #(.NUM_DATA_REG(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        address      = a;
        data_in      = d;
        data_write_n = wn;
        step(1);
        data_write_n = 2'b11;
        address      = 6'h00;
    endtask

    task automatic cpu_read(input logic [5:0] a, output logic [31:0] d);
        address = a;
        #1;
        d       = data_out;
        address = 6'h00;
    endtask

    task automatic pulse(input logic lvl, input int n);
        ui_in[0] = lvl;
        step(n);
    endtask

    logic [31:0] rd;

    initial begin
        rst_n        = 1'b0;
        ui_in        = 8'h00;
        address      = 6'h00;
        data_in      = 32'h0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        #1;
        check("reset data_out", data_out, 32'h0);
        check("reset uo_out", {24'h0, uo_out}, 32'h0);
        check("reset irq", {31'h0, user_interrupt}, 32'h0);
        check("data_ready", {31'h0, data_ready}, 32'h1);
        step(3);
        rst_n = 1'b1;
        step(2);
        for (int i = 0; i < 8; i++) cpu_write(6'h20 + 6'(4 * i), 32'h0, 2'b10);

        // Basic decode: thresholds 10/10, end index 3
        cpu_write(6'h04, 32'h0000_0A0A, 2'b10);
        cpu_write(6'h08, 32'd3, 2'b10);
        cpu_write(6'h00, 32'h0000_0F01, 2'b10);
        pulse(1'b1, 20);
        pulse(1'b0, 5);
        pulse(1'b1, 5);
        pulse(1'b0, 20);
        pulse(1'b1, 10);
        cpu_read(6'h20, rd);
        check("decode word0", rd, 32'h0000_0063);
        cpu_read(6'h00, rd);
        check("decode ctrl", rd, 32'h0000_030A);
        cpu_read(6'h08, rd);
        check("decode last_duration", rd, 32'h0014_0003);
        check("decode irq", {31'h0, user_interrupt}, 32'h1);
        check("decode uo_out idle", {24'h0, uo_out}, 32'h0000_0004);

        // Timeout end: p=2, timeout 50 ticks
        pulse(1'b0, 5);
        cpu_write(6'h04, 32'h0002_0A0A, 2'b10);
        cpu_write(6'h08, 32'd10, 2'b10);
        cpu_write(6'h20, 32'h0, 2'b10);
        cpu_write(6'h00, 32'h0032_0F1F, 2'b10);
        pulse(1'b1, 40);
        ui_in[0] = 1'b0;
        step(195);
        cpu_read(6'h00, rd);
        check("timeout not yet", {27'h0, rd[4:0]}, 32'h0000_0003);
        step(10);
        cpu_read(6'h00, rd);
        check("timeout ctrl", rd, 32'h0032_0106);
        cpu_read(6'h20, rd);
        check("timeout word0", rd, 32'h0000_0002);
        cpu_read(6'h08, rd);
        check("timeout last_duration", rd, 32'h000A_000A);

        // Glitch rejection: g=3, 3-clock spike ignored, 4-clock spike kept
        cpu_write(6'h04, 32'h0030_0A0A, 2'b10);
        cpu_write(6'h20, 32'h0, 2'b10);
        cpu_write(6'h00, 32'h0000_0F1F, 2'b10);
        pulse(1'b1, 12);
        pulse(1'b0, 3);
        pulse(1'b1, 15);
        pulse(1'b0, 10);
        pulse(1'b1, 10);
        pulse(1'b0, 4);
        pulse(1'b1, 10);
        pulse(1'b0, 10);
        ui_in[0] = 1'b1;
        step(6);
        cpu_read(6'h20, rd);
        check("glitch word0", rd, 32'h0000_0223);
        cpu_read(6'h00, rd);
        check("glitch index", {25'h0, rd[14:8]}, 32'd6);
        check("glitch receiving", {24'h0, uo_out}, 32'h0000_000C);

        // Abort mid-pulse, then restart
        cpu_write(6'h00, 32'h0000_0000, 2'b00);
        check("abort uo_out", {24'h0, uo_out}, 32'h0000_0004);
        cpu_read(6'h00, rd);
        check("abort ctrl", {16'h0, rd[15:0]}, 32'h0000_0602);
        ui_in[0] = 1'b0;
        step(8);
        cpu_write(6'h00, 32'h0000_0001, 2'b00);
        cpu_read(6'h00, rd);
        check("restart ctrl", {16'h0, rd[15:0]}, 32'h0000_0003);
        check("restart uo_out arm", {24'h0, uo_out}, 32'h0);

        // run=1 while running must not restart
        pulse(1'b1, 20);
        ui_in[0] = 1'b0;
        step(6);
        cpu_write(6'h00, 32'h0000_001F, 2'b00);
        cpu_read(6'h00, rd);
        check("no restart ctrl", {16'h0, rd[15:0]}, 32'h0000_0101);

        // W1C of status[1] on the same edge as the symbol write
        ui_in[0] = 1'b1;
        step(4);
        cpu_read(6'h00, rd);
        check("collision before", {16'h0, rd[15:0]}, 32'h0000_0101);
        cpu_write(6'h00, 32'h0000_0003, 2'b00);
        cpu_read(6'h00, rd);
        check("collision set wins", {16'h0, rd[15:0]}, 32'h0000_0203);

        // Mask status[1]
        cpu_write(6'h00, 32'h0000_0E03, 2'b01);
        ui_in[0] = 1'b0;
        step(6);
        cpu_read(6'h00, rd);
        check("masked ctrl", {16'h0, rd[15:0]}, 32'h0000_0301);
        check("masked irq", {31'h0, user_interrupt}, 32'h0);

        // Async reset mid-MEASURE
        cpu_write(6'h00, 32'h0000_0F01, 2'b01);
        cpu_write(6'h34, 32'hA5A5_5A5A, 2'b10);
        ui_in[0] = 1'b1;
        step(6);
        check("pre-reset irq", {31'h0, user_interrupt}, 32'h1);
        check("pre-reset uo_out", {24'h0, uo_out}, 32'h0000_000C);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset data_out", data_out, 32'h0);
        check("async reset uo_out", {24'h0, uo_out}, 32'h0);
        check("async reset irq", {31'h0, user_interrupt}, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);
        cpu_read(6'h34, rd);
        check("reset keeps word5", rd, 32'hA5A5_5A5A);
        cpu_read(6'h00, rd);
        check("post-reset ctrl", rd, 32'h0);
        cpu_read(6'h08, rd);
        check("post-reset cfg2", rd, 32'h0);

        // 64 short symbols: index reaches 64 and status[4] latches
        cpu_write(6'h04, 32'h0000_0A0A, 2'b10);
        cpu_write(6'h08, 32'd70, 2'b10);
        ui_in[0] = 1'b0;
        step(3);
        cpu_write(6'h00, 32'h0000_0F01, 2'b10);
        for (int i = 0; i < 65; i++) begin
            ui_in[0] = ~ui_in[0];
            step(2);
        end
        step(4);
        cpu_read(6'h00, rd);
        check("idx64 ctrl", {16'h0, rd[15:0]}, 32'h0000_4013);
        cpu_read(6'h20, rd);
        check("idx64 word0", rd, 32'h2222_2222);
        cpu_read(6'h2C, rd);
        check("idx64 word3", rd, 32'h2222_2222);
        cpu_read(6'h30, rd);
        check("idx64 word4 untouched", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
